unary_stream_encoder: RTL and testbench

- Upstream feeder for the unary square-root stage.
- Converts one binary word into a STREAM_LENGTH-beat unary bitstream whose ones-count equals the (saturated) word value.
- Drives the root stage's data bit and ready/strobe through a valid/ready handshake with backpressure.
- Accepts one word per stream and marks the final beat.

---
 rtl/unary_stream_encoder_pkg.sv | 24 ++
 rtl/unary_stream_encoder_if.sv | 36 +++
 rtl/unary_bit_generator.sv | 51 +++++
 rtl/unary_stream_encoder.sv | 134 +++++++++++++
 tb/tb_unary_stream_encoder.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/unary_stream_encoder_pkg.sv
// ============================================================================
// Module   : unary_stream_encoder_pkg
// Purpose  : Shared unary-stream types and constants (also used by root stage).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package unary_stream_encoder_pkg;

  localparam int c_DEFAULT_STREAM_LENGTH = 32;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_t;

  // Counter width able to hold the values 0..stream_length inclusive.
  function automatic int count_width(input int stream_length);
    return $clog2(stream_length + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/unary_stream_encoder_if.sv
// ============================================================================
// Module   : unary_stream_encoder_if
// Purpose  : Word-in / unary-bit-out handshake bundle of the stream encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface unary_stream_encoder_if
  import unary_stream_encoder_pkg::*;
#(
  parameter int COUNT_WIDTH = count_width(c_DEFAULT_STREAM_LENGTH)
);
  logic [COUNT_WIDTH-1:0] in_value;
  logic                   in_valid;
  logic                   in_ready;
  logic                   stream_bit;
  logic                   stream_valid;
  logic                   stream_ready;
  logic                   stream_last;
  logic                   saturated;
  logic                   busy;

  // Encoder side.
  modport master (
    input  in_value, in_valid, stream_ready,
    output in_ready, stream_bit, stream_valid, stream_last, saturated, busy
  );

  // Producer of words / consumer of the stream.
  modport slave (
    output in_value, in_valid, stream_ready,
    input  in_ready, stream_bit, stream_valid, stream_last, saturated, busy
  );
endinterface

`default_nettype wire

// File: rtl/unary_bit_generator.sv
// ============================================================================
// Module   : unary_bit_generator
// Purpose  : Bit for a given beat: thermometer compare, or error-accumulator
//            spreading when UNARY_STREAM_DITHER_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module unary_bit_generator #(
  parameter int STREAM_LENGTH = 32,
  parameter int COUNT_WIDTH   = 6
) (
  input  wire                   clk,
  input  wire                   reset,
  input  wire [COUNT_WIDTH-1:0] value,
  input  wire [COUNT_WIDTH-1:0] index,
  input  wire                   load,
  input  wire                   advance,
  output logic                  next_bit
);

`ifdef UNARY_STREAM_DITHER_EN
  localparam logic [COUNT_WIDTH:0] c_LEN = (COUNT_WIDTH+1)'(STREAM_LENGTH);

  logic [COUNT_WIDTH:0] r_acc;
  logic [COUNT_WIDTH:0] w_sum;
  wire                  w_unused_index = ^index;

  // r_acc holds the residue after the beat currently presented; a load
  // starts the new word from an empty accumulator.
  always_comb begin
    w_sum    = (load ? '0 : r_acc) + {1'b0, value};
    next_bit = (w_sum >= c_LEN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
    end else if (load || advance) begin
      r_acc <= next_bit ? (w_sum - c_LEN) : w_sum;
    end
  end
`else
  wire w_unused_ctrl = ^{clk, reset, load, advance};

  assign next_bit = (index < value);
`endif

endmodule

`default_nettype wire

// File: rtl/unary_stream_encoder.sv
// ============================================================================
// Module   : unary_stream_encoder
// Purpose  : Binary word -> STREAM_LENGTH-beat unary stream with backpressure.
//            Optional build macro: UNARY_STREAM_DITHER_EN (spread ones).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module unary_stream_encoder
  import unary_stream_encoder_pkg::*;
#(
  parameter int STREAM_LENGTH = c_DEFAULT_STREAM_LENGTH,
  parameter int COUNT_WIDTH   = count_width(STREAM_LENGTH)
) (
  input  wire                    clk,
  input  wire                    reset,
  unary_stream_encoder_if.master bus
);

  localparam logic [COUNT_WIDTH-1:0] c_LEN  = COUNT_WIDTH'(STREAM_LENGTH);
  localparam logic [COUNT_WIDTH-1:0] c_LAST = COUNT_WIDTH'(STREAM_LENGTH - 1);

  stream_state_t          r_state, w_state_n;
  logic [COUNT_WIDTH-1:0] r_beat, w_beat_n;
  logic [COUNT_WIDTH-1:0] r_value, w_value_n;
  logic                   r_stream_bit, w_stream_bit_n;
  logic                   r_stream_valid, w_stream_valid_n;
  logic                   r_stream_last, w_stream_last_n;
  logic                   r_saturated, w_saturated_n;
  logic                   r_busy, w_busy_n;

  logic [COUNT_WIDTH-1:0] w_clamped;
  logic [COUNT_WIDTH-1:0] w_beat_inc;
  logic [COUNT_WIDTH-1:0] w_gen_value;
  logic [COUNT_WIDTH-1:0] w_gen_index;
  logic                   w_accept;
  logic                   w_xfer;
  logic                   w_gen_bit;

  assign w_clamped  = (bus.in_value > c_LEN) ? c_LEN : bus.in_value;
  assign w_beat_inc = r_beat + COUNT_WIDTH'(1);
  assign w_accept   = bus.in_valid && (r_state == IDLE);
  assign w_xfer     = r_stream_valid && bus.stream_ready;

  // The generator always produces the bit of the beat about to be loaded.
  assign w_gen_value = (r_state == IDLE) ? w_clamped : r_value;
  assign w_gen_index = (r_state == IDLE) ? '0 : w_beat_inc;

  unary_bit_generator #(
    .STREAM_LENGTH(STREAM_LENGTH),
    .COUNT_WIDTH  (COUNT_WIDTH)
  ) u_bit_generator (
    .clk     (clk),
    .reset   (reset),
    .value   (w_gen_value),
    .index   (w_gen_index),
    .load    (w_accept),
    .advance (w_xfer && !r_stream_last),
    .next_bit(w_gen_bit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_beat         <= '0;
      r_value        <= '0;
      r_stream_bit   <= 1'b0;
      r_stream_valid <= 1'b0;
      r_stream_last  <= 1'b0;
      r_saturated    <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_n;
      r_beat         <= w_beat_n;
      r_value        <= w_value_n;
      r_stream_bit   <= w_stream_bit_n;
      r_stream_valid <= w_stream_valid_n;
      r_stream_last  <= w_stream_last_n;
      r_saturated    <= w_saturated_n;
      r_busy         <= w_busy_n;
    end
  end

  always_comb begin
    w_state_n        = r_state;
    w_beat_n         = r_beat;
    w_value_n        = r_value;
    w_stream_bit_n   = r_stream_bit;
    w_stream_valid_n = r_stream_valid;
    w_stream_last_n  = r_stream_last;
    w_saturated_n    = r_saturated;
    w_busy_n         = r_busy;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_n        = STREAM;
          w_value_n        = w_clamped;
          w_saturated_n    = (bus.in_value > c_LEN);
          w_beat_n         = '0;
          w_stream_bit_n   = w_gen_bit;
          w_stream_valid_n = 1'b1;
          w_stream_last_n  = (c_LAST == '0);
          w_busy_n         = 1'b1;
        end
      end
      STREAM: begin
        if (w_xfer) begin
          if (r_stream_last) begin
            w_state_n        = IDLE;
            w_stream_bit_n   = 1'b0;
            w_stream_valid_n = 1'b0;
            w_stream_last_n  = 1'b0;
            w_busy_n         = 1'b0;
          end else begin
            w_beat_n         = w_beat_inc;
            w_stream_bit_n   = w_gen_bit;
            w_stream_last_n  = (w_beat_inc == c_LAST);
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign bus.in_ready     = (r_state == IDLE);
  assign bus.stream_bit   = r_stream_bit;
  assign bus.stream_valid = r_stream_valid;
  assign bus.stream_last  = r_stream_last;
  assign bus.saturated    = r_saturated;
  assign bus.busy         = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_unary_stream_encoder.sv
// ============================================================================
// Module   : tb_unary_stream_encoder
// Purpose  : Self-checking bench for unary_stream_encoder (both bit rules).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_unary_stream_encoder;
  import unary_stream_encoder_pkg::*;

  localparam int L  = 32;
  localparam int CW = $clog2(L + 1);

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  bit   got_bit  [0:63];
  bit   got_last [0:63];
  bit   got_sat  [0:63];
  int   n_got, stall_changes, inready_high;
  bit   timed_out;

  unary_stream_encoder_if #(.COUNT_WIDTH(CW)) bus ();

  unary_stream_encoder #(.STREAM_LENGTH(L)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beat k of word v: thermometer, or evenly spread ones (floor-difference).
  function automatic bit exp_bit(input int v, input int k);
    int vc;
    vc = (v > L) ? L : v;
`ifdef UNARY_STREAM_DITHER_EN
    return (((k + 1) * vc) / L - (k * vc) / L) != 0;
`else
    return k < vc;
`endif
  endfunction

  task automatic send_word(input int v, input bit keep_valid);
    bus.in_value = CW'(v);
    bus.in_valid = 1'b1;
    @(negedge clk);
    if (!keep_valid) bus.in_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready
  task automatic collect(input int mode, input int budget);
    bit rdy, pb, pl, pstall, done;
    n_got = 0; stall_changes = 0; inready_high = 0; timed_out = 0;
    pstall = 0; done = 0; pb = 0; pl = 0;
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = ($urandom_range(0, 1) == 1);
      endcase
      bus.stream_ready = rdy;
      if (pstall && (bus.stream_bit !== pb || bus.stream_last !== pl)) stall_changes++;
      if (bus.in_ready) inready_high++;
      if (bus.stream_valid && rdy && n_got < 64) begin
        got_bit[n_got]  = bus.stream_bit;
        got_last[n_got] = bus.stream_last;
        got_sat[n_got]  = bus.saturated;
        n_got++;
        if (bus.stream_last) done = 1;
      end
      pstall = bus.stream_valid && !rdy;
      pb = bus.stream_bit;
      pl = bus.stream_last;
      @(negedge clk);
    end
    bus.stream_ready = 1'b0;
    if (!done) timed_out = 1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.in_value = '0; bus.stream_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.stream_bit, bus.stream_valid, bus.stream_last, bus.saturated, bus.busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got bit/valid/last/sat/busy=%b expected 00000",
               {bus.stream_bit, bus.stream_valid, bus.stream_last, bus.saturated, bus.busy});
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_single_word();
    int ones;
    send_word(5, 0);
    checks++;
    if (bus.stream_valid !== 1'b1 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL w5_latency: got valid=%b busy=%b in_ready=%b expected 1 1 0",
               bus.stream_valid, bus.busy, bus.in_ready);
    end
    collect(0, 100);
    checks++;
    if (timed_out || n_got != L || inready_high != 0) begin
      errors++;
      $display("FAIL w5_length: got beats=%0d timeout=%0b in_ready_cycles=%0d expected %0d 0 0",
               n_got, timed_out, inready_high, L);
    end
    ones = 0;
    for (int k = 0; k < n_got; k++) begin
      ones += got_bit[k];
      checks++;
      if (got_bit[k] !== exp_bit(5, k) || got_last[k] !== (k == L - 1)) begin
        errors++;
        $display("FAIL w5_beat[%0d]: got bit=%b last=%b expected bit=%b last=%b",
                 k, got_bit[k], got_last[k], exp_bit(5, k), (k == L - 1));
      end
    end
    checks++;
    if (ones != 5) begin errors++; $display("FAIL w5_ones: got %0d expected 5", ones); end
    checks++;
    if (bus.in_ready !== 1'b1 || bus.stream_valid !== 1'b0 || bus.stream_last !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL w5_end: got in_ready=%b valid=%b last=%b busy=%b expected 1 0 0 0",
               bus.in_ready, bus.stream_valid, bus.stream_last, bus.busy);
    end
  endtask

  task automatic test_boundaries();
    int vals[3] = '{0, 32, 40};
    for (int i = 0; i < 3; i++) begin
      send_word(vals[i], 0);
      collect(0, 100);
      checks++;
      if (timed_out || n_got != L) begin
        errors++;
        $display("FAIL bound_len v=%0d: got beats=%0d timeout=%0b expected %0d", vals[i], n_got, timed_out, L);
      end
      for (int k = 0; k < n_got; k++) begin
        checks++;
        if (got_bit[k] !== ((vals[i] == 0) ? 1'b0 : 1'b1) || got_sat[k] !== (vals[i] > L)) begin
          errors++;
          $display("FAIL bound_beat v=%0d k=%0d: got bit=%b sat=%b expected bit=%b sat=%b",
                   vals[i], k, got_bit[k], got_sat[k], (vals[i] != 0), (vals[i] > L));
        end
      end
    end
    @(negedge clk);
    checks++;
    if (bus.saturated !== 1'b1) begin
      errors++; $display("FAIL sat_hold_idle: got %b expected 1", bus.saturated);
    end
    send_word(5, 0);
    checks++;
    if (bus.saturated !== 1'b0) begin
      errors++; $display("FAIL sat_clear_on_accept: got %b expected 0", bus.saturated);
    end
    collect(0, 100);
  endtask

  task automatic test_stall();
    int ones;
    send_word(7, 1);
    collect(1, 400);
    bus.in_valid = 1'b0;
    checks++;
    if (timed_out || n_got != L || stall_changes != 0 || inready_high != 0) begin
      errors++;
      $display("FAIL stall_stream: got beats=%0d timeout=%0b stall_changes=%0d in_ready_cycles=%0d expected %0d 0 0 0",
               n_got, timed_out, stall_changes, inready_high, L);
    end
    ones = 0;
    for (int k = 0; k < n_got; k++) begin
      ones += got_bit[k];
      checks++;
      if (got_bit[k] !== exp_bit(7, k) || got_last[k] !== (k == L - 1)) begin
        errors++;
        $display("FAIL stall_beat[%0d]: got bit=%b last=%b expected bit=%b last=%b",
                 k, got_bit[k], got_last[k], exp_bit(7, k), (k == L - 1));
      end
    end
    checks++;
    if (ones != 7) begin errors++; $display("FAIL stall_ones: got %0d expected 7", ones); end
    @(negedge clk);
    checks++;
    if (bus.stream_valid !== 1'b0) begin
      errors++; $display("FAIL stall_no_extra_accept: got valid=%b expected 0", bus.stream_valid);
    end
  endtask

  task automatic test_reset_mid_stream();
    send_word(20, 0);
    bus.stream_ready = 1'b1;
    repeat (10) @(negedge clk);
    bus.stream_ready = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.stream_bit, bus.stream_valid, bus.stream_last, bus.saturated, bus.busy} !== 5'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got bit/valid/last/sat/busy=%b expected 00000",
               {bus.stream_bit, bus.stream_valid, bus.stream_last, bus.saturated, bus.busy});
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_in_ready: got %b expected 1", bus.in_ready);
    end
    @(negedge clk);
    send_word(3, 0);
    collect(0, 100);
    checks++;
    if (timed_out || n_got != L) begin
      errors++; $display("FAIL midreset_len: got beats=%0d timeout=%0b expected %0d", n_got, timed_out, L);
    end
    for (int k = 0; k < n_got; k++) begin
      checks++;
      if (got_bit[k] !== exp_bit(3, k) || got_last[k] !== (k == L - 1)) begin
        errors++;
        $display("FAIL midreset_beat[%0d]: got bit=%b last=%b expected bit=%b last=%b",
                 k, got_bit[k], got_last[k], exp_bit(3, k), (k == L - 1));
      end
    end
  endtask

  task automatic test_back_to_back();
    int v, ones;
    for (int w = 0; w < 8; w++) begin
      v = $urandom_range(0, 63);
      send_word(v, 0);
      checks++;
      if (bus.stream_valid !== 1'b1) begin
        errors++; $display("FAIL rnd_latency v=%0d: got valid=%b expected 1", v, bus.stream_valid);
      end
      collect(2, 1000);
      checks++;
      if (timed_out || n_got != L || inready_high != 0) begin
        errors++;
        $display("FAIL rnd_len v=%0d: got beats=%0d timeout=%0b in_ready_cycles=%0d expected %0d 0 0",
                 v, n_got, timed_out, inready_high, L);
      end
      ones = 0;
      for (int k = 0; k < n_got; k++) begin
        ones += got_bit[k];
        checks++;
        if (got_bit[k] !== exp_bit(v, k) || got_last[k] !== (k == L - 1) || got_sat[k] !== (v > L)) begin
          errors++;
          $display("FAIL rnd_beat v=%0d k=%0d: got bit=%b last=%b sat=%b expected %b %b %b",
                   v, k, got_bit[k], got_last[k], got_sat[k], exp_bit(v, k), (k == L - 1), (v > L));
        end
      end
      checks++;
      if (ones != ((v > L) ? L : v)) begin
        errors++; $display("FAIL rnd_ones v=%0d: got %0d expected %0d", v, ones, (v > L) ? L : v);
      end
      checks++;
      if (bus.in_ready !== 1'b1 || bus.stream_valid !== 1'b0) begin
        errors++;
        $display("FAIL rnd_gap v=%0d: got in_ready=%b valid=%b expected 1 0", v, bus.in_ready, bus.stream_valid);
      end
    end
  endtask

`ifdef UNARY_STREAM_DITHER_EN
  task automatic test_dither_pattern();
    int vals[3] = '{8, 16, 32};
    bit e;
    for (int i = 0; i < 3; i++) begin
      send_word(vals[i], 0);
      collect(0, 100);
      for (int k = 0; k < n_got; k++) begin
        case (vals[i])
          8:       e = (k % 4 == 3);
          16:      e = (k % 2 == 1);
          default: e = 1'b1;
        endcase
        checks++;
        if (got_bit[k] !== e) begin
          errors++;
          $display("FAIL dither v=%0d k=%0d: got %b expected %b", vals[i], k, got_bit[k], e);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_boundaries();
    test_stall();
    test_reset_mid_stream();
    test_back_to_back();
`ifdef UNARY_STREAM_DITHER_EN
    test_dither_pattern();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
